// File: rtl/cpu_mem_responder_if.sv
// Handshake bundle between the CPU control-unit strobes and the memory responder.
interface cpu_mem_responder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              ins_req;
    logic [ADDR_W-1:0] ins_addr;
    logic              da_req;
    logic              da_we;
    logic [ADDR_W-1:0] da_addr;
    logic [DATA_W-1:0] wdata;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] rdata_ins;
    logic [DATA_W-1:0] rdata_da;
    logic              ready;
    logic              ready_ins;
    logic              busy;
    logic              err;

    modport master (
        output ins_req, ins_addr, da_req, da_we, da_addr, wdata,
               load_en, load_addr, load_data,
        input  rdata_ins, rdata_da, ready, ready_ins, busy, err
    );

    modport slave (
        input  ins_req, ins_addr, da_req, da_we, da_addr, wdata,
               load_en, load_addr, load_data,
        output rdata_ins, rdata_da, ready, ready_ins, busy, err
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// Single-ported RAM responder serving fetch and data strobes with wait states,
// one pending slot per request type and a sticky error flag.
module cpu_mem_responder #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 5,
    parameter int WAIT_CYCLES = 1
) (
    input logic                clk,
    input logic                rst,
    cpu_mem_responder_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
    typedef enum logic [1:0] {K_INS, K_RD, K_WR} kind_t;

    localparam state_t S_FIRST = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    kind_t             kind_q, kind_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              pend_ins_q, pend_ins_d;
    logic [ADDR_W-1:0] pins_addr_q, pins_addr_d;
    logic              pend_da_q, pend_da_d;
    logic              pda_we_q, pda_we_d;
    logic [ADDR_W-1:0] pda_addr_q, pda_addr_d;
    logic [DATA_W-1:0] pda_wdata_q, pda_wdata_d;
    logic              ins_prev_q, da_prev_q;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic              ready_ins_q, ready_ins_d;
    logic [DATA_W-1:0] rdata_ins_q, rdata_ins_d;
    logic [DATA_W-1:0] rdata_da_q, rdata_da_d;

    logic              new_ins, new_da, take_ins, take_da;
    logic              in_ins, in_da, load_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // A request is the first cycle of a high strobe; a held level is the same request.
    assign new_ins = bus.ins_req & ~ins_prev_q;
    assign new_da  = bus.da_req & ~da_prev_q;
    assign in_ins  = (state_q != S_IDLE) && (kind_q == K_INS);
    assign in_da   = (state_q != S_IDLE) && (kind_q != K_INS);
    assign load_ok = (state_q == S_IDLE) && !bus.ins_req && !bus.da_req
                     && !pend_ins_q && !pend_da_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        kind_d      = kind_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pend_ins_d  = pend_ins_q;
        pins_addr_d = pins_addr_q;
        pend_da_d   = pend_da_q;
        pda_we_d    = pda_we_q;
        pda_addr_d  = pda_addr_q;
        pda_wdata_d = pda_wdata_q;
        err_d       = err_q;
        ready_d     = 1'b0;
        ready_ins_d = 1'b0;
        rdata_ins_d = rdata_ins_q;
        rdata_da_d  = rdata_da_q;
        mem_we      = 1'b0;
        mem_waddr   = addr_q;
        mem_wdata   = wdata_q;
        take_ins    = 1'b0;
        take_da     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pend_ins_q || pend_da_q || new_ins || new_da) begin
                    state_d = S_FIRST;
                    cnt_d   = CNT_INIT;
                end
                if (pend_ins_q) begin
                    kind_d     = K_INS;
                    addr_d     = pins_addr_q;
                    pend_ins_d = 1'b0;
                end else if (pend_da_q) begin
                    kind_d    = pda_we_q ? K_WR : K_RD;
                    addr_d    = pda_addr_q;
                    wdata_d   = pda_wdata_q;
                    pend_da_d = 1'b0;
                end else if (new_ins) begin
                    kind_d   = K_INS;
                    addr_d   = bus.ins_addr;
                    take_ins = 1'b1;
                end else if (new_da) begin
                    kind_d  = bus.da_we ? K_WR : K_RD;
                    addr_d  = bus.da_addr;
                    wdata_d = bus.wdata;
                    take_da = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ACCESS: begin
                state_d     = S_RESP;
                ready_d     = 1'b1;
                ready_ins_d = (kind_q == K_INS);
                case (kind_q)
                    K_INS:   rdata_ins_d = mem[addr_q];
                    K_RD:    rdata_da_d  = mem[addr_q];
                    default: mem_we      = 1'b1;
                endcase
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Requests not taken this edge go to their pending slot unless that type is already owed.
        if (new_ins && !take_ins) begin
            if (pend_ins_q || in_ins) begin
                err_d = 1'b1;
            end else begin
                pend_ins_d  = 1'b1;
                pins_addr_d = bus.ins_addr;
            end
        end
        if (new_da && !take_da) begin
            if (pend_da_q || in_da) begin
                err_d = 1'b1;
            end else begin
                pend_da_d   = 1'b1;
                pda_we_d    = bus.da_we;
                pda_addr_d  = bus.da_addr;
                pda_wdata_d = bus.wdata;
            end
        end

        if (bus.load_en) begin
            if (load_ok) begin
                mem_we    = 1'b1;
                mem_waddr = bus.load_addr;
                mem_wdata = bus.load_data;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            kind_q      <= K_INS;
            addr_q      <= '0;
            wdata_q     <= '0;
            pend_ins_q  <= 1'b0;
            pins_addr_q <= '0;
            pend_da_q   <= 1'b0;
            pda_we_q    <= 1'b0;
            pda_addr_q  <= '0;
            pda_wdata_q <= '0;
            ins_prev_q  <= 1'b0;
            da_prev_q   <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            ready_ins_q <= 1'b0;
            rdata_ins_q <= '0;
            rdata_da_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            kind_q      <= kind_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            pend_ins_q  <= pend_ins_d;
            pins_addr_q <= pins_addr_d;
            pend_da_q   <= pend_da_d;
            pda_we_q    <= pda_we_d;
            pda_addr_q  <= pda_addr_d;
            pda_wdata_q <= pda_wdata_d;
            ins_prev_q  <= bus.ins_req;
            da_prev_q   <= bus.da_req;
            err_q       <= err_d;
            ready_q     <= ready_d;
            ready_ins_q <= ready_ins_d;
            rdata_ins_q <= rdata_ins_d;
            rdata_da_q  <= rdata_da_d;
        end
    end

    // RAM is not reset; a write pending while rst is high is simply dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.ready     = ready_q;
    assign bus.ready_ins = ready_ins_q;
    assign bus.rdata_ins = rdata_ins_q;
    assign bus.rdata_da  = rdata_da_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: two instances (1 and 0 wait states) share stimulus
// and are checked every cycle against a countdown-based reference model.
module tb_cpu_mem_responder;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int N  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic          ins_req = 1'b0, da_req = 1'b0, da_we = 1'b0, load_en = 1'b0;
    logic [AW-1:0] ins_addr = '0, da_addr = '0, load_addr = '0;
    logic [DW-1:0] wdata = '0, load_data = '0;

    logic [N-1:0][DW-1:0] d_rdi, d_rdd;
    logic [N-1:0]         d_rdy, d_rdyi, d_busy, d_err;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_i
        cpu_mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
        assign bus.ins_req   = ins_req;
        assign bus.ins_addr  = ins_addr;
        assign bus.da_req    = da_req;
        assign bus.da_we     = da_we;
        assign bus.da_addr   = da_addr;
        assign bus.wdata     = wdata;
        assign bus.load_en   = load_en;
        assign bus.load_addr = load_addr;
        assign bus.load_data = load_data;
        cpu_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(g == 0 ? 1 : 0)) dut (
            .clk(clk), .rst(rst), .bus(bus)
        );
        assign d_rdi[g]  = bus.rdata_ins;
        assign d_rdd[g]  = bus.rdata_da;
        assign d_rdy[g]  = bus.ready;
        assign d_rdyi[g] = bus.ready_ins;
        assign d_busy[g] = bus.busy;
        assign d_err[g]  = bus.err;
    end

    // Reference model: rem counts edges until the access is finished (0 = idle).
    int            m_rem[N], m_kind[N];
    logic [AW-1:0] m_addr[N], m_pia[N], m_pda[N];
    logic [DW-1:0] m_wd[N], m_pdwd[N], m_rdi[N], m_rdd[N];
    bit            m_pi[N], m_pd[N], m_pdwe[N], m_pvi[N], m_pvd[N];
    bit            m_rdy[N], m_rdyi[N], m_err[N];
    logic [DW-1:0] m_mem[N][32];

    int rt[N][2];
    bit rti[N][2];
    int nr[N], bcnt[N];

    function automatic int wait_of(int g);
        return (g == 0) ? 1 : 0;
    endfunction

    task automatic model_reset(int g);
        m_rem[g] = 0; m_kind[g] = 0; m_pi[g] = 0; m_pd[g] = 0;
        m_pvi[g] = 0; m_pvd[g] = 0; m_rdi[g] = '0; m_rdd[g] = '0;
        m_rdy[g] = 0; m_rdyi[g] = 0; m_err[g] = 0;
    endtask

    task automatic model_start(int g, int kind, logic [AW-1:0] a, logic [DW-1:0] d);
        m_kind[g] = kind; m_addr[g] = a; m_wd[g] = d;
        m_rem[g]  = wait_of(g) + 2;
    endtask

    task automatic model_step(int g);
        bit ni, nd, idle, opi, opd, took_i, took_d, in_i, in_d;
        ni   = ins_req && !m_pvi[g];
        nd   = da_req && !m_pvd[g];
        idle = (m_rem[g] == 0);
        opi  = m_pi[g];
        opd  = m_pd[g];
        in_i = !idle && (m_kind[g] == 0);
        in_d = !idle && (m_kind[g] != 0);
        took_i = 0; took_d = 0;
        m_rdy[g] = 0; m_rdyi[g] = 0;
        if (m_rem[g] == 2) begin
            case (m_kind[g])
                0:       m_rdi[g] = m_mem[g][m_addr[g]];
                1:       m_rdd[g] = m_mem[g][m_addr[g]];
                default: m_mem[g][m_addr[g]] = m_wd[g];
            endcase
            m_rdy[g]  = 1;
            m_rdyi[g] = (m_kind[g] == 0);
        end
        if (!idle) m_rem[g]--;
        else if (opi) begin model_start(g, 0, m_pia[g], '0); m_pi[g] = 0; end
        else if (opd) begin model_start(g, m_pdwe[g] ? 2 : 1, m_pda[g], m_pdwd[g]); m_pd[g] = 0; end
        else if (ni) begin model_start(g, 0, ins_addr, '0); took_i = 1; end
        else if (nd) begin model_start(g, da_we ? 2 : 1, da_addr, wdata); took_d = 1; end
        if (ni && !took_i) begin
            if (opi || in_i) m_err[g] = 1;
            else begin m_pi[g] = 1; m_pia[g] = ins_addr; end
        end
        if (nd && !took_d) begin
            if (opd || in_d) m_err[g] = 1;
            else begin m_pd[g] = 1; m_pdwe[g] = da_we; m_pda[g] = da_addr; m_pdwd[g] = wdata; end
        end
        if (load_en) begin
            if (idle && !ins_req && !da_req && !opi && !opd) m_mem[g][load_addr] = load_data;
            else m_err[g] = 1;
        end
        m_pvi[g] = ins_req;
        m_pvd[g] = da_req;
    endtask

    task automatic check(string nm, int g, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, g, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int g = 0; g < N; g++) begin
            check("rdata_ins", g, int'(d_rdi[g]), int'(m_rdi[g]));
            check("rdata_da", g, int'(d_rdd[g]), int'(m_rdd[g]));
            check("ready", g, int'(d_rdy[g]), int'(m_rdy[g]));
            check("ready_ins", g, int'(d_rdyi[g]), int'(m_rdyi[g]));
            check("busy", g, int'(d_busy[g]), (m_rem[g] != 0) ? 1 : 0);
            check("err", g, int'(d_err[g]), int'(m_err[g]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) for (int g = 0; g < N; g++) model_step(g);
        @(negedge clk);
        compare_all();
    endtask

    task automatic assert_rst();
        rst = 1'b1;
        for (int g = 0; g < N; g++) model_reset(g);
    endtask

    // Strobes are held for the first cycle only; records ready ticks and busy cycles.
    task automatic run_watch(int ncyc);
        for (int g = 0; g < N; g++) begin
            nr[g] = 0; bcnt[g] = 0;
            rt[g][0] = 0; rt[g][1] = 0; rti[g][0] = 0; rti[g][1] = 0;
        end
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            if (c == 1) begin ins_req = 1'b0; da_req = 1'b0; end
            for (int g = 0; g < N; g++) begin
                if (d_busy[g]) bcnt[g]++;
                if (d_rdy[g] && nr[g] < 2) begin
                    rt[g][nr[g]]  = c;
                    rti[g][nr[g]] = d_rdyi[g];
                    nr[g]++;
                end
            end
        end
    endtask

    initial begin
        for (int g = 0; g < N; g++) model_reset(g);
        #1 assert_rst();
        tick();
        tick();
        rst = 1'b0;
        for (int g = 0; g < N; g++) begin
            check("reset_rdata_ins", g, int'(d_rdi[g]), 0);
            check("reset_busy_err", g, int'({d_busy[g], d_err[g], d_rdy[g]}), 0);
        end

        // Preload every word so all later reads are defined.
        for (int a = 0; a < 32; a++) begin
            load_en   = 1'b1;
            load_addr = AW'(a);
            load_data = (a == 3) ? 8'hA5 : (a == 4) ? 8'h2C : DW'($urandom);
            tick();
        end
        load_en = 1'b0;

        // Single fetch of address 3.
        ins_req = 1'b1; ins_addr = 5'd3;
        run_watch(6);
        check("fetch_latency", 0, rt[0][0], 3);
        check("fetch_ready_ins", 0, int'(rti[0][0]), 1);
        check("fetch_busy_cycles", 0, bcnt[0], 3);
        check("fetch_data", 0, int'(d_rdi[0]), 'hA5);
        check("fetch_latency", 1, rt[1][0], 2);
        check("fetch_busy_cycles", 1, bcnt[1], 2);

        // Write 5A to address 7 then read it back.
        da_req = 1'b1; da_we = 1'b1; da_addr = 5'd7; wdata = 8'h5A;
        run_watch(6);
        check("write_latency", 0, rt[0][0], 3);
        da_req = 1'b1; da_we = 1'b0; da_addr = 5'd7;
        run_watch(6);
        check("read_ready_ins", 0, int'(rti[0][0]), 0);
        check("read_data", 0, int'(d_rdd[0]), 'h5A);
        check("read_data", 1, int'(d_rdd[1]), 'h5A);
        check("rdata_ins_held", 0, int'(d_rdi[0]), 'hA5);

        // Simultaneous fetch of 4 and read of 3.
        ins_req = 1'b1; ins_addr = 5'd4; da_req = 1'b1; da_we = 1'b0; da_addr = 5'd3;
        run_watch(12);
        check("simul_fetch_tick", 0, rt[0][0], 3);
        check("simul_fetch_is_ins", 0, int'(rti[0][0]), 1);
        check("simul_read_tick", 0, rt[0][1], 7);
        check("simul_read_is_ins", 0, int'(rti[0][1]), 0);
        check("simul_read_tick", 1, rt[1][1], 5);
        check("simul_fetch_data", 0, int'(d_rdi[0]), 'h2C);
        check("simul_read_data", 0, int'(d_rdd[0]), 'hA5);
        check("simul_err", 0, int'(d_err[0]), 0);

        // Overflow: two separate data pulses while a fetch is in flight.
        ins_req = 1'b1; ins_addr = 5'd0;
        tick();
        ins_req = 1'b0; da_req = 1'b1; da_we = 1'b0; da_addr = 5'd4;
        tick();
        da_req = 1'b0; da_addr = 5'd5;
        tick();
        da_req = 1'b1;
        tick();
        da_req = 1'b0;
        repeat (8) tick();
        check("overflow_err", 0, int'(d_err[0]), 1);
        check("overflow_err", 1, int'(d_err[1]), 1);
        check("overflow_pended_data", 0, int'(d_rdd[0]), 'h2C);
        repeat (4) tick();
        check("err_sticky", 0, int'(d_err[0]), 1);

        // Reset while a write of FF to address 3 is in flight.
        da_req = 1'b1; da_we = 1'b1; da_addr = 5'd3; wdata = 8'hFF;
        tick();
        da_req = 1'b0;
        assert_rst();
        #1;
        for (int g = 0; g < N; g++) begin
            check("rst_async_rdata", g, int'({d_rdi[g], d_rdd[g]}), 0);
            check("rst_async_flags", g, int'({d_rdy[g], d_rdyi[g], d_busy[g], d_err[g]}), 0);
        end
        tick();
        rst = 1'b0; da_we = 1'b0;
        ins_req = 1'b1; ins_addr = 5'd3;
        run_watch(6);
        check("write_aborted", 0, int'(d_rdi[0]), 'hA5);
        check("write_aborted", 1, int'(d_rdi[1]), 'hA5);
        check("fetch_latency_w0", 1, rt[1][0], 2);
        check("fetch_latency_w1", 0, rt[0][0], 3);

        // Backdoor load while busy is refused.
        ins_req = 1'b1; ins_addr = 5'd0;
        tick();
        ins_req = 1'b0; load_en = 1'b1; load_addr = 5'd3; load_data = 8'h11;
        tick();
        load_en = 1'b0;
        repeat (4) tick();
        check("load_busy_err", 0, int'(d_err[0]), 1);
        ins_req = 1'b1; ins_addr = 5'd3;
        run_watch(6);
        check("load_busy_unchanged", 0, int'(d_rdi[0]), 'hA5);
        check("load_busy_unchanged", 1, int'(d_rdi[1]), 'hA5);

        // Random traffic with occasional resets.
        assert_rst();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            ins_req   = ($urandom_range(0, 3) == 0);
            ins_addr  = AW'($urandom);
            da_req    = ($urandom_range(0, 3) == 0);
            da_we     = $urandom_range(0, 1) == 1;
            da_addr   = AW'($urandom);
            wdata     = DW'($urandom);
            load_en   = ($urandom_range(0, 15) == 0);
            load_addr = AW'($urandom);
            load_data = DW'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                assert_rst();
                tick();
                rst = 1'b0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the accumulator CPU's control-unit strobes.
- Serves instruction fetches (ins_req, driven by the fetch-state enable) and data reads/writes (da_req/da_we, driven by the decode/execute-state enables) from one single-ported internal RAM.
- Inserts a configurable number of wait states and returns data with a one-cycle ready pulse.
- Buffers one pending request per type when a strobe arrives while busy.

Parameters:
- DATA_W, 8, word width; instruction = {opcode[2:0], addr[4:0]}.
- ADDR_W, 5, address width; RAM depth = 2**ADDR_W.
- WAIT_CYCLES, 1, wait states inserted per access; legal range 0..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- ins_req  input  1  instruction fetch strobe, level or pulse.
- ins_addr  input  ADDR_W  fetch address (PC).
- da_req  input  1  data access strobe.
- da_we  input  1  1 = write, 0 = read; qualified by da_req.
- da_addr  input  ADDR_W  operand address.
- wdata  input  DATA_W  write data (accumulator).
- load_en  input  1  backdoor program-load write.
- load_addr  input  ADDR_W  load address.
- load_data  input  DATA_W  load data.
- rdata_ins  output  DATA_W  last fetched instruction, held until the next fetch completes.
- rdata_da  output  DATA_W  last read data, held until the next data read completes.
- ready  output  1  one-cycle pulse when an access completes.
- ready_ins  output  1  qualifies ready as a fetch completion.
- busy  output  1  high when the FSM is not in IDLE.
- err  output  1  sticky error flag, cleared only by rst.

Behaviour:
- Reset values: state IDLE; rdata_ins = 0, rdata_da = 0, ready = 0, ready_ins = 0, busy = 0, err = 0; pending flags cleared; wait counter = 0. RAM contents are not reset.
- Reset mid-operation aborts the access. A write still in WAIT is never committed.
- FSM states and transitions:
  - IDLE: selects a request. Priority: pending_ins, then pending_da, then live ins_req, then live da_req. On selection it latches addr, kind (INS/RD/WR) and, for WR, wdata. Goes to WAIT with cnt = WAIT_CYCLES-1, or straight to ACCESS if WAIT_CYCLES = 0.
  - WAIT: decrements cnt each cycle; goes to ACCESS when cnt = 0.
  - ACCESS: performs the RAM operation at this edge. INS loads rdata_ins; RD loads rdata_da; WR writes mem[addr] = latched wdata. Goes to RESP.
  - RESP: ready = 1 for exactly this cycle; ready_ins = 1 if kind = INS. Goes to IDLE.
- Latency: request accepted at edge N, ready high in the cycle after edge N+WAIT_CYCLES+1. With WAIT_CYCLES = 1 that is 3 cycles from accept to ready. Output data is valid whenever ready is high.
- Simultaneous live ins_req and da_req in IDLE: the fetch is served and the data request goes to pending_da in the same edge.
- Strobes arriving while busy, or while a pending flag of the other type is being served: they set pending_ins or pending_da. A strobe that is still high at the next IDLE edge counts as the same request; it does not create a duplicate.
- Overflow: a new strobe edge (rising edge of ins_req or da_req) while that type is already pending or in service sets err. The request is dropped.
- Pending da_we, da_addr and wdata are captured with the pending flag. Later changes on those inputs are ignored.
- load_en: honoured only in IDLE with no live or pending request; writes mem[load_addr] = load_data at that edge and does not assert ready. load_en in any other condition is ignored and sets err.
- Address arithmetic: none; addresses are used directly. No out-of-range condition exists because depth = 2**ADDR_W.
- busy is combinational from state (state != IDLE). ready, ready_ins and the rdata outputs are registered.

Test Plan:
- Reset then load: load mem[3] = 8'hA5, mem[4] = 8'h2C. Then ins_req = 1 with ins_addr = 3, held 1 cycle. Required: ready and ready_ins high exactly 3 cycles after accept; rdata_ins = 8'hA5; busy high for 3 cycles.
- Write then read with WAIT_CYCLES = 1: da_req, da_we = 1, da_addr = 7, wdata = 8'h5A, then a read of da_addr = 7. Required: second ready has ready_ins = 0 and rdata_da = 8'h5A; rdata_ins unchanged.
- Simultaneous ins_req (addr 4) and da_req read (addr 3) in the same cycle. Required: fetch completes first with rdata_ins = 8'h2C; data read completes 4 cycles later with rdata_da = 8'hA5; err = 0.
- Overflow: while a fetch is busy, pulse da_req twice as separate rising edges. Required: the first pulse is pended and served; the second sets err = 1, which stays high until rst.
- Reset mid-write: da_req write of 8'hFF to addr 3, rst asserted during WAIT. Required: all outputs return to 0 immediately; a subsequent fetch of addr 3 returns 8'hA5. Rerun with WAIT_CYCLES = 0 and confirm the 2-cycle accept-to-ready latency.
- load_en asserted while busy. Required: err = 1 and the target word is unchanged on readback.
